// File: rtl/serial_mag_comp_pkg.sv
// ----------------------------------------------------------------------------
// serial_mag_comp_pkg
// Shared definitions for the serial magnitude comparator:
//   - FSM state encoding (IDLE / RUN)
//   - result bundle type
//   - helper to size the digit counter (never narrower than 1 bit)
// ----------------------------------------------------------------------------
package serial_mag_comp_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // One-hot comparison result; all-zero only while a comparison is pending.
  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  // Counter width for a given number of digit pairs, at least 1 bit so the
  // WIDTH=2 case still has a legal (always-zero) counter.
  function automatic int cnt_width(input int digits);
    if (digits <= 1) begin
      return 1;
    end else begin
      return $clog2(digits);
    end
  endfunction

endpackage : serial_mag_comp_pkg

// File: rtl/serial_mag_comp_twobit.sv
// ----------------------------------------------------------------------------
// twoBitComp
// Combinational unsigned comparator for one 2-bit digit pair.
// Ports:
//   a, b     : 2-bit unsigned digits
//   greater  : a > b
//   less     : a < b
//   equal    : a == b
// Exactly one output is high for any input.
// ----------------------------------------------------------------------------
module twoBitComp (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       greater,
  output logic       less,
  output logic       equal
);

  assign greater = (a > b);
  assign less    = (a < b);
  assign equal   = (a == b);

endmodule : twoBitComp

// File: rtl/serial_mag_comp.sv
// ----------------------------------------------------------------------------
// serial_mag_comp
// Multi-cycle unsigned magnitude comparator. Operands are latched on an
// accepted start and examined one 2-bit digit pair per clock, MSB pair first,
// through a single twoBitComp instance. The comparison stops at the first
// unequal pair; equal operands take WIDTH/2 cycles.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : request a comparison (only honoured while idle)
//   a, b     : WIDTH-bit unsigned operands, sampled with an accepted start
//   busy     : comparison in progress
//   done     : one-cycle pulse, result valid
//   greater  : A > B   (registered, held until next accepted start)
//   less     : A < B   (registered, held until next accepted start)
//   equal    : A == B  (registered, held until next accepted start)
// ----------------------------------------------------------------------------
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             less,
  output logic             equal
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = cnt_width(DIGITS);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Odd or zero widths cannot be split into whole digit pairs.
  generate
    if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
      $error("serial_mag_comp: WIDTH must be even and >= 2");
    end
  endgenerate

  logic             r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  cmp_res_t         r_res;

  logic             w_state_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_done_nxt;
  cmp_res_t         w_res_nxt;

  logic             w_gt;
  logic             w_lt;
  logic             w_eq;

  // The digit comparator always looks at the current top pair.
  twoBitComp u_digit_cmp (
    .a       (r_a[WIDTH-1 -: 2]),
    .b       (r_b[WIDTH-1 -: 2]),
    .greater (w_gt),
    .less    (w_lt),
    .equal   (w_eq)
  );

  // Next-state logic for the sequencer, operand shifters and result.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_res_nxt   = r_res;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_cnt_nxt   = CNT_LOAD;
          w_res_nxt   = '{gt: 1'b0, lt: 1'b0, eq: 1'b0};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_gt) begin
          w_state_nxt  = ST_IDLE;
          w_done_nxt   = 1'b1;
          w_res_nxt.gt = 1'b1;
        end else if (w_lt) begin
          w_state_nxt  = ST_IDLE;
          w_done_nxt   = 1'b1;
          w_res_nxt.lt = 1'b1;
        end else if (r_cnt != CNT_ZERO) begin
          // Zeros shift in from the right, so low bits never reach the
          // comparator with stale or undefined content.
          w_a_nxt   = r_a << 2;
          w_b_nxt   = r_b << 2;
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_state_nxt  = ST_IDLE;
          w_done_nxt   = 1'b1;
          w_res_nxt.eq = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, operand, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_cnt   <= CNT_ZERO;
      r_done  <= 1'b0;
      r_res   <= '{gt: 1'b0, lt: 1'b0, eq: 1'b0};
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_res   <= w_res_nxt;
    end
  end

  // busy is the RUN state bit itself, so it drops in the done cycle.
  assign busy    = (r_state == ST_RUN);
  assign done    = r_done;
  assign greater = r_res.gt;
  assign less    = r_res.lt;
  assign equal   = r_res.eq;

endmodule : serial_mag_comp

// File: tb/tb_serial_mag_comp.sv
// ----------------------------------------------------------------------------
// tb_serial_mag_comp
// Self-checking bench for serial_mag_comp (WIDTH=8). A driver pushes the
// expected result and completion cycle into a scoreboard queue when it issues
// a start; a monitor on the falling edge pops and compares on every done.
// ----------------------------------------------------------------------------
module tb_serial_mag_comp;

  localparam int WIDTH  = 8;
  localparam int DIGITS = WIDTH / 2;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             gt;
    logic             lt;
    logic             eq;
    int               lat;
  } vec_t;

  typedef struct {
    logic gt;
    logic lt;
    logic eq;
    int   start_cyc;
    int   done_cyc;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             greater;
  logic             less;
  logic             equal;

  int   total;
  int   bad;
  int   cyc;
  exp_t sbq[$];
  logic [2:0] last_res;
  logic prev_done;
  vec_t tbl[11];

  serial_mag_comp #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .greater (greater),
    .less    (less),
    .equal   (equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: scan digit pairs MSB first, stop at first difference.
  function automatic void model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                output logic g, output logic l, output logic e,
                                output int lat);
    int px;
    int py;
    g = 1'b0; l = 1'b0; e = 1'b1; lat = DIGITS;
    for (int k = 0; k < DIGITS; k++) begin
      px = int'((x >> (WIDTH - 2 - 2 * k)) & 8'd3);
      py = int'((y >> (WIDTH - 2 - 2 * k)) & 8'd3);
      if (px != py) begin
        g = (px > py); l = (px < py); e = 1'b0; lat = k + 1;
        break;
      end
    end
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("result_gle", {29'd0, greater, less, equal}, {29'd0, e.gt, e.lt, e.eq});
          chk("busy_at_done", {31'd0, busy}, 32'd0);
          last_res = {e.gt, e.lt, e.eq};
        end
      end else if (sbq.size() > 0) begin
        if (cyc > sbq[0].done_cyc) begin
          chk("done_timeout", cyc, sbq[0].done_cyc);
          void'(sbq.pop_front());
        end else if (cyc > sbq[0].start_cyc) begin
          chk("busy_in_run", {31'd0, busy}, 32'd1);
          chk("result_clear_in_run", {29'd0, greater, less, equal}, 32'd0);
        end
      end else begin
        chk("result_hold", {29'd0, greater, less, equal}, {29'd0, last_res});
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic push_exp(input logic g, input logic l, input logic e, input int lat);
    exp_t x;
    x.gt = g; x.lt = l; x.eq = e;
    x.start_cyc = cyc;
    x.done_cyc  = cyc + 1 + lat;
    sbq.push_back(x);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) chk("drain_bound", sbq.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_vec(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic g, input logic l, input logic e, input int lat);
    @(negedge clk);
    start = 1'b1; a = va; b = vb;
    push_exp(g, l, e, lat);
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom);   // operand changes during RUN must not matter
    b = WIDTH'($urandom);
    wait_idle();
  endtask

  initial begin
    logic g, l, e;
    int   lat;
    logic [WIDTH-1:0] ra, rb;
    int   seen;

    total = 0; bad = 0; cyc = 0;
    last_res = 3'b000; prev_done = 1'b0;
    tbl[0]  = '{8'hB4, 8'hB1, 1'b1, 1'b0, 1'b0, 3};
    tbl[1]  = '{8'h3C, 8'hC3, 1'b0, 1'b1, 1'b0, 1};
    tbl[2]  = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, 4};
    tbl[3]  = '{8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 4};
    tbl[4]  = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 4};
    tbl[5]  = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1};
    tbl[6]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4};
    tbl[7]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 4};
    tbl[8]  = '{8'hC0, 8'hC4, 1'b0, 1'b1, 1'b0, 3};
    tbl[9]  = '{8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 4};
    tbl[10] = '{8'h0F, 8'h10, 1'b0, 1'b1, 1'b0, 2};

    // Reset state
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    #1;
    chk("reset_outputs", {27'd0, busy, done, greater, less, equal}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_after_reset", {27'd0, busy, done, greater, less, equal}, 32'd0);
    end

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i].a, tbl[i].b, tbl[i].gt, tbl[i].lt, tbl[i].eq, tbl[i].lat);
    end

    // Random vectors, biased so later digit pairs decide often
    for (int i = 0; i < 6; i++) begin
      ra = WIDTH'($urandom_range(0, 255));
      rb = (ra & 8'hF0) | WIDTH'($urandom_range(0, 15));
      model(ra, rb, g, l, e, lat);
      run_vec(ra, rb, g, l, e, lat);
    end

    // Start accepted in the done cycle
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h5A;
    push_exp(1'b0, 1'b0, 1'b1, 4);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("restart_done_seen", seen, 32'd1);
    start = 1'b1; a = 8'h00; b = 8'h01;
    push_exp(1'b0, 1'b1, 1'b0, 4);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1; a = 8'h00; b = 8'h01;
    push_exp(1'b0, 1'b1, 1'b0, 4);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset in the middle of a comparison
    @(negedge clk);
    start = 1'b1; a = 8'h00; b = 8'h01;
    push_exp(1'b0, 1'b1, 1'b0, 4);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_before_midreset", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {27'd0, busy, done, greater, less, equal}, 32'd0);
    sbq.delete();
    last_res = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_serial_mag_comp
